// File: rtl/a2d_sched_pkg.sv
// Shared types and constants for the ADC128S request scheduler.
package a2d_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX1,
    WT1,
    TX2,
    WT2,
    CPLT
  } state_t;

  localparam int CMD_W      = 16;
  localparam int CMD_CH_LSB = 11;
  localparam int RES_W      = 12;

endpackage

// File: rtl/a2d_req_scheduler_if.sv
// Requester-side and SPI-master-side signals of the A2D scheduler, bundled.
interface a2d_req_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CHW  = 3
);
  import a2d_sched_pkg::*;

  logic [NREQ-1:0]     req;
  logic [NREQ*CHW-1:0] chnl;
  logic [NREQ-1:0]     rdy;
  logic [RES_W-1:0]    res;
  logic                busy;
  logic                wrt;
  logic [CMD_W-1:0]    cmd;
  logic                done;
  logic [CMD_W-1:0]    rd_data;

  modport master (
    input  req, chnl, done, rd_data,
    output rdy, res, busy, wrt, cmd
  );

  modport slave (
    output req, chnl, done, rd_data,
    input  rdy, res, busy, wrt, cmd
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] grant,
  output logic            valid
);

  logic [IDXW-1:0] cand;

  // Searching offsets 1..NREQ puts 'last' itself at lowest priority.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last) + k) % NREQ);
      if (!valid && req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/a2d_req_scheduler.sv
// Round-robin sharing of one ADC128S among NREQ requesters; each grant runs two SPI words.
module a2d_req_scheduler
  import a2d_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CHW  = 3
) (
  input logic               clk,
  input logic               rst_n,
  a2d_req_scheduler_if.master bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   winner;
  logic [CMD_W-1:0]  cmd_q;
  logic [RES_W-1:0]  res_q;
  logic [IDXW-1:0]   arb_grant;
  logic              arb_valid;
  logic [NREQ-1:0]   rdy_d;
  logic              wrt_d;
  logic              busy_d;
  logic              unused_rd_hi;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req   (bus.req),
    .last  (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Winner and command are frozen at grant; only WT2's done updates the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= IDXW'(NREQ - 1);
      winner <= '0;
      cmd_q  <= '0;
      res_q  <= '0;
    end else begin
      if (state == IDLE && arb_valid) begin
        winner <= arb_grant;
        ptr    <= arb_grant;
        cmd_q  <= CMD_W'(bus.chnl[arb_grant*CHW +: CHW]) << CMD_CH_LSB;
      end
      if (state == WT2 && bus.done) begin
        res_q <= bus.rd_data[RES_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wrt_d     = 1'b0;
    rdy_d     = '0;
    busy_d    = (state != IDLE);
    case (state)
      IDLE: if (arb_valid) state_nxt = TX1;
      TX1: begin
        wrt_d     = 1'b1;
        state_nxt = WT1;
      end
      WT1: if (bus.done) state_nxt = TX2;
      TX2: begin
        wrt_d     = 1'b1;
        state_nxt = WT2;
      end
      WT2: if (bus.done) state_nxt = CPLT;
      CPLT: begin
        rdy_d     = NREQ'(1) << winner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rdy  = rdy_d;
  assign bus.wrt  = wrt_d;
  assign bus.busy = busy_d;
  assign bus.cmd  = cmd_q;
  assign bus.res  = res_q;

  assign unused_rd_hi = ^bus.rd_data[CMD_W-1:RES_W];

endmodule
